// File: rtl/uart_rx_word.sv
// uart_rx_word -- 8N1 UART receiver with little-endian word assembly.
//
// The RX line is oversampled in the clk domain. Each good byte is reported
// on byte_data/byte_valid and dropped into the next slot of a word buffer.
// Slot 0 is the first byte received. When the last slot fills, the
// assembled word is presented on word/word_valid.
//
// Ports:
//    clk          system clock; all logic runs on its rising edge
//    rst          asynchronous reset, active low
//    rx           serial line; asynchronous to clk; idles high
//    byte_data    last good byte received
//    byte_valid   one-cycle pulse when byte_data updates
//    word         last completed word; held until the next completion
//    word_valid   one-cycle pulse when word updates; coincides with byte_valid
//    frame_error  one-cycle pulse when a stop bit is sampled low
//    busy         high whenever the receiver is not idle
module uart_rx_word #(
   parameter int CLK_FREQ     = 200_000_000,
   parameter int BAUD_RATE    = 9600,
   parameter int NUM_BYTES    = 4,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   output logic [7:0]             byte_data,
   output logic                   byte_valid,
   output logic [8*NUM_BYTES-1:0] word,
   output logic                   word_valid,
   output logic                   frame_error,
   output logic                   busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_LOAD    = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
   localparam int IDX_W        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int WORD_W       = 8 * NUM_BYTES;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t            state_reg, state_next;
   logic              rx_meta_reg, rx_s_reg;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [7:0]        shift_reg, shift_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [WORD_W-1:0] asm_reg, asm_next;
   logic [TO_W-1:0]   idle_cnt_reg, idle_cnt_next;
   logic [7:0]        byte_data_reg, byte_data_next;
   logic              byte_valid_reg, byte_valid_next;
   logic [WORD_W-1:0] word_reg, word_next;
   logic              word_valid_reg, word_valid_next;
   logic              frame_error_reg, frame_error_next;

   logic              cnt_zero;
   logic              last_slot;
   logic [WORD_W-1:0] asm_merged;

   assign cnt_zero  = (cnt_reg == '0);
   assign last_slot = (idx_reg == IDX_W'(NUM_BYTES - 1));

   // Assembly buffer with the freshly shifted byte dropped into slot idx.
   // Used both to update the buffer and, on the last slot, as the new word
   // so the completing byte appears in the same cycle as its byte_valid.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
         assign asm_merged[8*gi +: 8] = (idx_reg == IDX_W'(gi)) ? shift_reg
                                                                : asm_reg[8*gi +: 8];
      end
   endgenerate

   // State and datapath registers. The synchronizer resets to the idle
   // level so that reset release never looks like a start edge by itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_reg     <= 1'b1;
         rx_s_reg        <= 1'b1;
         state_reg       <= S_IDLE;
         cnt_reg         <= '0;
         bit_idx_reg     <= '0;
         shift_reg       <= '0;
         idx_reg         <= '0;
         asm_reg         <= '0;
         idle_cnt_reg    <= '0;
         byte_data_reg   <= '0;
         byte_valid_reg  <= 1'b0;
         word_reg        <= '0;
         word_valid_reg  <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         rx_meta_reg     <= rx;
         rx_s_reg        <= rx_meta_reg;
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         bit_idx_reg     <= bit_idx_next;
         shift_reg       <= shift_next;
         idx_reg         <= idx_next;
         asm_reg         <= asm_next;
         idle_cnt_reg    <= idle_cnt_next;
         byte_data_reg   <= byte_data_next;
         byte_valid_reg  <= byte_valid_next;
         word_reg        <= word_next;
         word_valid_reg  <= word_valid_next;
         frame_error_reg <= frame_error_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (!rx_s_reg) state_next = S_START;
         S_START: if (cnt_zero) state_next = rx_s_reg ? S_IDLE : S_DATA;
         S_DATA:  if (cnt_zero && bit_idx_reg == 3'd7) state_next = S_STOP;
         S_STOP:  if (cnt_zero) state_next = rx_s_reg ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s_reg) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output / datapath logic: computes next values of the counters, the
   // shift register, the word buffer and the registered output pulses.
   always_comb begin
      cnt_next         = cnt_reg;
      bit_idx_next     = bit_idx_reg;
      shift_next       = shift_reg;
      idx_next         = idx_reg;
      asm_next         = asm_reg;
      idle_cnt_next    = idle_cnt_reg;
      byte_data_next   = byte_data_reg;
      byte_valid_next  = 1'b0;
      word_next        = word_reg;
      word_valid_next  = 1'b0;
      frame_error_next = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (!rx_s_reg) begin
               cnt_next      = CNT_W'(HALF_LOAD);
               idle_cnt_next = '0;
            end else if (idx_reg != '0) begin
               // A partial word left idle too long is abandoned silently.
               if (idle_cnt_reg == TO_W'(TIMEOUT_CLKS - 1)) begin
                  idx_next      = '0;
                  idle_cnt_next = '0;
               end else begin
                  idle_cnt_next = idle_cnt_reg + TO_W'(1);
               end
            end else begin
               idle_cnt_next = '0;
            end
         end
         S_START: begin
            if (cnt_zero) begin
               cnt_next     = CNT_W'(CLKS_PER_BIT - 1);
               bit_idx_next = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               shift_next   = {rx_s_reg, shift_reg[7:1]};
               bit_idx_next = bit_idx_reg + 3'd1;
               cnt_next     = CNT_W'(CLKS_PER_BIT - 1);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_zero) begin
               if (rx_s_reg) begin
                  byte_data_next  = shift_reg;
                  byte_valid_next = 1'b1;
                  asm_next        = asm_merged;
                  if (last_slot) begin
                     word_next       = asm_merged;
                     word_valid_next = 1'b1;
                     idx_next        = '0;
                  end else begin
                     idx_next = idx_reg + IDX_W'(1);
                  end
               end else begin
                  frame_error_next = 1'b1;
                  idx_next         = '0;
               end
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign byte_data   = byte_data_reg;
   assign byte_valid  = byte_valid_reg;
   assign word        = word_reg;
   assign word_valid  = word_valid_reg;
   assign frame_error = frame_error_reg;
   assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word -- self-checking bench for uart_rx_word at 16 clocks/bit.
// A negedge monitor logs every byte, word and frame-error pulse.
// Scenario results are compared against an expectation model that works at
// the level of whole frames.
`timescale 1ns/1ps
module tb_uart_rx_word;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx  = 1'b1;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic [31:0] word;
   logic        word_valid;
   logic        frame_error;
   logic        busy;

   uart_rx_word #(
      .CLK_FREQ(160), .BAUD_RATE(10), .NUM_BYTES(4), .TIMEOUT_BITS(20)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .byte_data(byte_data), .byte_valid(byte_valid),
      .word(word), .word_valid(word_valid),
      .frame_error(frame_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- monitor ----------------
   logic [7:0]  got_bytes[$];
   logic [31:0] got_words[$];
   int          got_wpos[$];
   int          got_fe = 0;
   int          viol   = 0;
   logic        prev_bv = 1'b0, prev_wv = 1'b0, prev_fe = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         prev_bv <= 1'b0;
         prev_wv <= 1'b0;
         prev_fe <= 1'b0;
      end else begin
         if (byte_valid) got_bytes.push_back(byte_data);
         if (word_valid) begin
            got_words.push_back(word);
            got_wpos.push_back(got_bytes.size());
         end
         if (frame_error) got_fe <= got_fe + 1;
         if ((byte_valid && prev_bv) || (word_valid && prev_wv) ||
             (frame_error && prev_fe) || (frame_error && byte_valid) ||
             (word_valid && !byte_valid))
            viol <= viol + 1;
         prev_bv <= byte_valid;
         prev_wv <= word_valid;
         prev_fe <= frame_error;
      end
   end

   // ---------------- expectation model ----------------
   logic [7:0]  exp_bytes[$];
   logic [31:0] exp_words[$];
   int          exp_wpos[$];
   int          exp_fe;
   int          m_idx = 0;
   logic [7:0]  m_slot [4];
   int          b0, w0, fe0, v0;

   task automatic model_frame(input logic [7:0] b, input logic ok);
      if (ok) begin
         exp_bytes.push_back(b);
         m_slot[m_idx] = b;
         m_idx++;
         if (m_idx == 4) begin
            exp_words.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
            exp_wpos.push_back(exp_bytes.size());
            m_idx = 0;
         end
      end else begin
         exp_fe++;
         m_idx = 0;
      end
   endtask

   // An idle gap longer than the timeout discards any partial word.
   task automatic model_gap(input int bits);
      if (bits > 20) m_idx = 0;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- line driver (always entered at a negedge) ----------------
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (CPB * n) @(negedge clk);
   endtask

   task automatic begin_scn();
      b0  = got_bytes.size();
      w0  = got_words.size();
      fe0 = got_fe;
      v0  = viol;
      exp_bytes.delete();
      exp_words.delete();
      exp_wpos.delete();
      exp_fe = 0;
   endtask

   task automatic end_scn(input string name);
      int nb, nw;
      nb = got_bytes.size() - b0;
      nw = got_words.size() - w0;
      check({name, " byte count"}, 64'(nb), 64'(exp_bytes.size()));
      for (int i = 0; i < nb && i < exp_bytes.size(); i++)
         check({name, " byte"}, 64'(got_bytes[b0 + i]), 64'(exp_bytes[i]));
      check({name, " word count"}, 64'(nw), 64'(exp_words.size()));
      for (int i = 0; i < nw && i < exp_words.size(); i++) begin
         check({name, " word"}, 64'(got_words[w0 + i]), 64'(exp_words[i]));
         check({name, " word position"}, 64'(got_wpos[w0 + i] - b0), 64'(exp_wpos[i]));
      end
      if (exp_words.size() > 0)
         check({name, " held word"}, 64'(word), 64'(exp_words[exp_words.size() - 1]));
      check({name, " frame_error count"}, 64'(got_fe - fe0), 64'(exp_fe));
      check({name, " pulse rules"}, 64'(viol - v0), 64'(0));
      $display("[TB] scenario %s: %0d bytes, %0d words, %0d frame errors",
               name, nb, nw, got_fe - fe0);
   endtask

   // ---------------- table of single-frame vectors ----------------
   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic        exp_bv;
      logic        exp_fe;
      logic        exp_wv;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got time limit, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] bb [8];
      logic [7:0] b;
      logic       ok;
      int         gap, first_hi, last_hi, busy_low;
      bit         prev_err;

      vecs[0]  = '{8'hEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[1]  = '{8'hBE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[2]  = '{8'hAD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[3]  = '{8'h0B, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0BAD_BEEF};
      vecs[4]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_BEEF};
      vecs[5]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_BEEF};
      vecs[6]  = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0BAD_BEEF};
      vecs[7]  = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_BEEF};
      vecs[8]  = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_BEEF};
      vecs[9]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_BEEF};
      vecs[10] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5AA5_8001};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset byte_data", 64'(byte_data), 64'(0));
      check("reset byte_valid", 64'(byte_valid), 64'(0));
      check("reset word", 64'(word), 64'(0));
      check("reset word_valid", 64'(word_valid), 64'(0));
      check("reset frame_error", 64'(frame_error), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      rst = 1'b1;
      idle_bits(2);

      // Table-driven single frames
      foreach (vecs[k]) begin
         begin_scn();
         send_frame(vecs[k].data, vecs[k].stop);
         idle_bits(1);
         check("vec byte_valid count", 64'(got_bytes.size() - b0), 64'(vecs[k].exp_bv));
         if (vecs[k].exp_bv && got_bytes.size() > b0)
            check("vec byte_data", 64'(got_bytes[b0]), 64'(vecs[k].data));
         check("vec frame_error count", 64'(got_fe - fe0), 64'(vecs[k].exp_fe));
         check("vec word_valid count", 64'(got_words.size() - w0), 64'(vecs[k].exp_wv));
         check("vec word", 64'(word), 64'(vecs[k].exp_word));
         check("vec pulse rules", 64'(viol - v0), 64'(0));
         $display("[TB] vec %0d rx 0x%02h stop=%0d -> bytes=%0d fe=%0d word=0x%08h",
                  k, vecs[k].data, vecs[k].stop, got_bytes.size() - b0, got_fe - fe0, word);
      end

      // Glitch: 5-clock low pulse must be rejected and busy must fall quickly
      begin_scn();
      first_hi = -1;
      last_hi  = -1;
      rx = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c == 5) rx = 1'b1;
         @(negedge clk);
         if (busy) begin
            if (first_hi < 0) first_hi = c;
            last_hi = c;
         end
      end
      check("glitch busy seen", 64'(first_hi >= 0), 64'(1));
      check("glitch busy falls within 9 clks", 64'(last_hi < 5 + 9), 64'(1));
      idle_bits(2);
      end_scn("glitch");

      // Frame error followed by a long low hold, then a clean word
      begin_scn();
      send_frame(8'h55, 1'b0);
      model_frame(8'h55, 1'b0);
      rx = 1'b0;
      busy_low = 0;
      repeat (40) begin
         @(negedge clk);
         if (!busy) busy_low++;
      end
      check("break holds busy", 64'(busy_low), 64'(0));
      idle_bits(1);
      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b1);
         model_frame(8'(i), 1'b1);
      end
      idle_bits(2);
      end_scn("frame error");

      // Timeout of a partial word
      begin_scn();
      send_frame(8'h11, 1'b1); model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1); model_frame(8'h22, 1'b1);
      idle_bits(21);           model_gap(21);
      bb[0] = 8'hAA; bb[1] = 8'hBB; bb[2] = 8'hCC; bb[3] = 8'hDD;
      for (int i = 0; i < 4; i++) begin
         send_frame(bb[i], 1'b1);
         model_frame(bb[i], 1'b1);
      end
      idle_bits(2);
      end_scn("timeout");

      // Eight bytes back-to-back at full line rate
      begin_scn();
      bb[0] = 8'hDE; bb[1] = 8'hAD; bb[2] = 8'hBE; bb[3] = 8'hEF;
      bb[4] = 8'hCA; bb[5] = 8'hFE; bb[6] = 8'hBA; bb[7] = 8'hBE;
      for (int i = 0; i < 8; i++) begin
         send_frame(bb[i], 1'b1);
         model_frame(bb[i], 1'b1);
      end
      idle_bits(2);
      end_scn("back-to-back");

      // Reset during bit 4 of the second byte
      begin_scn();
      send_frame(8'h99, 1'b1);
      model_frame(8'h99, 1'b1);
      b = 8'h3C;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = b[4];
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b0;
      m_idx = 0;
      rx = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("outputs in reset",
               {20'h0, byte_data, byte_valid, word, word_valid, frame_error, busy}, 64'(0));
      end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      idle_bits(2);
      bb[0] = 8'h78; bb[1] = 8'h56; bb[2] = 8'h34; bb[3] = 8'h12;
      for (int i = 0; i < 4; i++) begin
         send_frame(bb[i], 1'b1);
         model_frame(bb[i], 1'b1);
      end
      idle_bits(2);
      end_scn("reset mid-frame");

      // Randomized frames, gaps and stop-bit errors
      begin_scn();
      idle_bits(22);
      model_gap(22);
      prev_err = 1'b0;
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6)      gap = 0;
         else if (r < 9) gap = $urandom_range(1, 3);
         else            gap = $urandom_range(22, 24);
         if (prev_err && gap == 0) gap = 1;
         if (gap > 0) idle_bits(gap);
         model_gap(gap);
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 7) != 0);
         send_frame(b, ok);
         model_frame(b, ok);
         if (!ok) begin
            rx = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
         end
         prev_err = !ok;
         $display("[TB] rand %0d: gap=%0d byte=0x%02h stop=%0d", n, gap, b, ok);
      end
      idle_bits(2);
      end_scn("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
UART receiver, 8N1, that is the receive-side counterpart of the uart_tx link used to stream MT19937 output. It oversamples the RX line in the system clock domain and recovers bytes. It assembles NUM_BYTES consecutive bytes, least-significant byte first, into one word. Intended use: accept a host-supplied seed (for example to drive external_seed_value of mt_fsm) and loop back and check generated numbers.

Parameters:
CLK_FREQ, 200_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 20833 at defaults)
NUM_BYTES, 4, bytes per assembled word; word width = 8*NUM_BYTES
TIMEOUT_BITS, 20, idle bit-periods after which a partial word is discarded

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (block in reset while rst=0)
rx  input  1  serial line, asynchronous to clk, idles high
byte_data  output  8  last good received byte
byte_valid  output  1  one-cycle pulse: byte_data updated
word  output  8*NUM_BYTES  last completed word, held until next completion
word_valid  output  1  one-cycle pulse: word updated
frame_error  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while receiving a frame (any state other than IDLE)

Behaviour:
- Reset values: byte_data=0, byte_valid=0, word=0, word_valid=0, frame_error=0, busy=0, byte index=0, state=IDLE.
- Synchronizer: rx passes through 2 flops, both reset to 1. All decisions use the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rx_s=0, load the bit counter and go to START.
- START: wait CLKS_PER_BIT/2 clocks, then sample rx_s.
  - Sample 0: go to DATA with a full CLKS_PER_BIT wait.
  - Sample 1: treat as a glitch, return to IDLE with no output.
- DATA: sample rx_s every CLKS_PER_BIT clocks, 8 samples, LSB first, shifted into a shift register. After the 8th sample go to STOP.
- STOP: sample rx_s one CLKS_PER_BIT later.
  - Sample 1 (good byte): on the next cycle byte_data=shift register and byte_valid=1. The byte is written into word-assembly slot idx (bits 8*idx+7 : 8*idx), and idx increments. Return to IDLE.
  - Sample 0 (frame error): pulse frame_error on the next cycle. Discard the byte, set idx=0, discard the partial word, go to BREAK.
- BREAK: remain until rx_s=1, then go to IDLE. This prevents a held-low line from re-triggering start.
- Word completion: when the good byte fills slot NUM_BYTES-1, then in the same cycle as its byte_valid:
  - word takes the full assembly (including the byte just received);
  - word_valid=1;
  - idx wraps to 0.
- word keeps its value across frame errors and timeouts. Only a completion updates it.
- Timeout: an idle counter runs in IDLE while idx≠0. When it reaches TIMEOUT_BITS*CLKS_PER_BIT, set idx=0 with no output pulse. The counter clears on entering START.
- Pulses: byte_valid, word_valid and frame_error are never high for more than one cycle. frame_error and byte_valid are mutually exclusive.
- Latency: from the stop-bit sample point to byte_valid is 1 clk.
- Back-to-back frames: the next start edge may arrive half a bit after the stop sample. No byte may be lost at full line rate.
- Reset mid-frame: all state returns to reset values immediately. Any partial byte or word is lost. After rst releases with rx low, the block waits in IDLE and may start on that level. A glitch check then rejects the frame if rx returns high.
- Counter widths: wide enough for TIMEOUT_BITS*CLKS_PER_BIT without overflow.

Test Plan:
All scenarios use CLK_FREQ=160, BAUD_RATE=10 (CLKS_PER_BIT=16).
- Bytes 0xEF,0xBE,0xAD,0x0B sent at 8N1 → four byte_valid pulses with those values. word=0x0BADBEEF, with word_valid coincident with the 4th byte_valid.
- rx low pulse of 5 clks from idle → no byte_valid, no frame_error; busy returns low within 9 clks.
- Byte 0x55 with stop bit forced 0, then rx held low 40 clks, then 0x01,0x02,0x03,0x04 → one frame_error pulse, no byte_valid for 0x55, no restart during the low hold. word=0x04030201.
- 0x11,0x22, then idle 21 bit times, then 0xAA,0xBB,0xCC,0xDD → the timeout discards the partial word; word=0xDDCCBBAA. No word containing 0x22 or 0x11 ever appears.
- Reset asserted during bit 4 of the 2nd byte, released, then 4 fresh bytes 0x78,0x56,0x34,0x12 → all outputs 0 during reset; word=0x12345678.
- Eight bytes sent back-to-back with zero idle gap → two word_valid pulses, each word correct, eight byte_valid pulses, no frame_error.
